// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, bubble instruction and reset PC.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StFault
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/f_IF_ID.sv
// IF/ID pipeline register: clear loads a bubble, enable low holds the current contents.
module f_IF_ID
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pcplus4_i,
    input  logic        valid_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            instr_o   <= NOP_INSTR;
            pc_o      <= '0;
            pcplus4_o <= '0;
            valid_o   <= 1'b0;
        end else if (en_i) begin
            instr_o   <= instr_i;
            pc_o      <= pc_i;
            pcplus4_o <= pcplus4_i;
            valid_o   <= valid_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, execute redirects, IF/ID register.
// FETCH_MISALIGN_EN enables the sticky misaligned-redirect FAULT state.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic        PCJalSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignF
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         drop_q, drop_d;

    logic [31:0]  target;
    logic         resp, deliver, from_hold, accepted;
    logic [31:0]  ifid_instr, ifid_pc, ifid_pc4;
    logic         ifid_valid;
    logic         unused_lsb;

    assign unused_lsb = ALUResultE[0];

    always_comb begin
        target = PCJalSrcE ? {ALUResultE[31:1], 1'b0} : PCTargetE;
`ifdef FETCH_MISALIGN_EN
        MisalignF = (state_q == StFault);
`else
        target[1:0] = 2'b00;
        MisalignF   = 1'b0;
`endif
    end

    always_comb begin
        resp      = (state_q == StWait) && imem_rvalid;
        deliver   = resp && !drop_q && !StallD;
        from_hold = (state_q == StHold) && !StallD && !PCSrcE;
        // Back-to-back issue in the response cycle unless the response must be parked.
        imem_req  = (state_q == StReq) || (resp && (drop_q || !StallD));
    end

    assign accepted  = imem_req && imem_ready;
    assign imem_addr = pcf_q;

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        inflight_pc_d = inflight_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        drop_d        = drop_q;

        if (accepted) begin
            inflight_pc_d = pcf_q;
            pcf_d         = pcf_q + 32'd4;
        end
        if (PCSrcE && (state_q != StFault)) begin
            pcf_d = target;
        end

        if (resp) begin
            drop_d = 1'b0;
        end
        // A redirect poisons whichever request will still be outstanding after this edge.
        if (PCSrcE && (accepted || ((state_q == StWait) && !imem_rvalid))) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            StReq: begin
                if (accepted) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (!drop_q && StallD && !PCSrcE) begin
                        state_d      = StHold;
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = inflight_pc_q;
                    end else begin
                        state_d = accepted ? StWait : StReq;
                    end
                end
            end
            StHold: begin
                if (PCSrcE || !StallD) state_d = StReq;
            end
            default: state_d = state_q;
        endcase

`ifdef FETCH_MISALIGN_EN
        if (PCSrcE && target[1]) begin
            state_d = StFault;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StReq;
            pcf_q         <= RESET_PC;
            inflight_pc_q <= '0;
            hold_instr_q  <= NOP_INSTR;
            hold_pc_q     <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            inflight_pc_q <= inflight_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            drop_q        <= drop_d;
        end
    end

    always_comb begin
        if (deliver) begin
            ifid_instr = imem_rdata;
            ifid_pc    = inflight_pc_q;
            ifid_valid = 1'b1;
        end else if (from_hold) begin
            ifid_instr = hold_instr_q;
            ifid_pc    = hold_pc_q;
            ifid_valid = 1'b1;
        end else begin
            ifid_instr = NOP_INSTR;
            ifid_pc    = '0;
            ifid_valid = 1'b0;
        end
        ifid_pc4 = ifid_valid ? (ifid_pc + 32'd4) : '0;
    end

    f_IF_ID u_if_id (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (FlushD),
        .en_i      (!StallD),
        .instr_i   (ifid_instr),
        .pc_i      (ifid_pc),
        .pcplus4_i (ifid_pc4),
        .valid_i   (ifid_valid),
        .instr_o   (InstrD),
        .pc_o      (PCD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal pins, then randomized traffic
// checked every cycle against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, StallD, FlushD, PCSrcE, PCJalSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignF;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCJalSrcE  (PCJalSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .MisalignF  (MisalignF)
    );

    int total = 0;
    int bad   = 0;

    // Memory: one pending request answered mem_lat cycles after acceptance.
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat  = 1;
    bit          after_rst = 1'b0;

    // Model: fetch PC, outstanding request, parked response, IF/ID contents.
    bit          m_live = 1'b0;
    logic [31:0] m_pcf, m_out_pc, m_hold_instr, m_hold_pc;
    bit          m_out, m_drop, m_held, m_fault;
    logic [31:0] m_instr, m_pcd, m_pc4;
    bit          m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit fl, input bit ps, input bit js,
                        input logic [31:0] tg, input logic [31:0] al, input bit rdy);
        logic [31:0] raw, tgt, rdata;
        bit rv, resp, deliver, park, req, acc, from_hold;
        @(negedge clk);
        if (m_live) begin
            chk("InstrD", InstrD, m_instr);
            chk("PCD", PCD, m_pcd);
            chk("PCPlus4D", PCPlus4D, m_pc4);
            chk("ValidD", 32'(ValidD), 32'(m_valid));
            chk("MisalignF", 32'(MisalignF), 32'(m_fault));
        end
        rv    = 1'b0;
        rdata = $urandom;
        if (!rst && mem_busy && mem_cnt == 0) begin
            rv    = 1'b1;
            rdata = mem_addr ^ KEY;
        end else if (!rst && after_rst) begin
            rv = 1'b1;  // stray response right after reset must be ignored
        end
        reset       = rst;
        StallD      = st;
        FlushD      = fl;
        PCSrcE      = ps;
        PCJalSrcE   = js;
        PCTargetE   = tg;
        ALUResultE  = al;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rdata;
        #1;
        if (rst) begin
            m_pcf   = 32'h0;
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_held  = 1'b0;
            m_fault = 1'b0;
            m_instr = NOP;
            m_pcd   = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_live  = 1'b1;
            mem_busy  = 1'b0;
            after_rst = 1'b1;
            return;
        end
        after_rst = 1'b0;

        raw       = js ? {al[31:1], 1'b0} : tg;
        tgt       = MisEn ? raw : {raw[31:2], 2'b00};
        resp      = m_out && rv;
        deliver   = resp && !m_drop && !st;
        park      = resp && !m_drop && st && !ps;
        from_hold = m_held && !st && !ps;
        req       = !m_fault && ((!m_out && !m_held) || (resp && (m_drop || !st)));
        acc       = req && rdy;
        chk("imem_req", 32'(imem_req), 32'(req));
        chk("imem_addr", imem_addr, m_pcf);

        if (fl) begin
            m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            if (deliver) begin
                m_instr = rdata; m_pcd = m_out_pc; m_pc4 = m_out_pc + 32'd4; m_valid = 1'b1;
            end else if (from_hold) begin
                m_instr = m_hold_instr; m_pcd = m_hold_pc; m_pc4 = m_hold_pc + 32'd4;
                m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end
        end
        if (park) begin
            m_held = 1'b1; m_hold_instr = rdata; m_hold_pc = m_out_pc;
        end else if (m_held && (!st || ps)) begin
            m_held = 1'b0;
        end
        if (resp) m_drop = 1'b0;
        if (ps && (acc || (m_out && !rv))) m_drop = 1'b1;
        if (acc) begin
            m_out = 1'b1; m_out_pc = m_pcf;
        end else if (resp) begin
            m_out = 1'b0;
        end
        if (!m_fault) begin
            if (MisEn && ps && tgt[1]) begin
                m_fault = 1'b1; m_out = 1'b0; m_held = 1'b0;
            end
            if (ps) m_pcf = tgt;
            else if (acc) m_pcf = m_pcf + 32'd4;
        end

        if (rv && mem_busy) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (imem_req && rdy) begin
            mem_busy = 1'b1; mem_addr = imem_addr; mem_cnt = mem_lat - 1;
        end
    endtask

    task automatic go(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        mem_lat = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCJalSrcE = 1'b0;
        PCTargetE = '0; ALUResultE = '0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0;

        // Zero-wait streaming, then ready low for three cycles at 0x10.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            go(!(c >= 5 && c <= 7));
            if (c <= 5) chk("s1_addr", imem_addr, 32'(4 * (c - 1)));
            else if (c <= 8) chk("s1_addr_hold", imem_addr, 32'h10);
            if (c <= 2) begin
                chk("s1_valid0", 32'(ValidD), 32'h0);
                chk("s1_instr0", InstrD, NOP);
                chk("s1_pcd0", PCD, 32'h0);
            end else if (c <= 6) begin
                chk("s1_pcd", PCD, 32'(4 * (c - 3)));
                chk("s1_instr", InstrD, 32'(4 * (c - 3)) ^ KEY);
                chk("s1_valid", 32'(ValidD), 32'h1);
            end else if (c <= 9) begin
                chk("s1_bubble", 32'(ValidD), 32'h0);
            end else begin
                chk("s1_resume", PCD, 32'h10);
            end
        end

        // Redirect to 0x200 while the 0x8 request is still outstanding.
        do_reset();
        go(1'b1); go(1'b1);
        mem_lat = 2;
        go(1'b1);
        mem_lat = 1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
        chk("s2_req_wait", 32'(imem_req), 32'h0);
        go(1'b1);
        chk("s2_req", 32'(imem_req), 32'h1);
        chk("s2_addr", imem_addr, 32'h200);
        go(1'b1);
        chk("s2_dropped", 32'(ValidD), 32'h0);
        go(1'b1);
        chk("s2_pcd", PCD, 32'h200);
        chk("s2_instr", InstrD, 32'h200 ^ KEY);

        // StallD for two cycles as the 0x4 response arrives.
        do_reset();
        go(1'b1); go(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("s3_req_hold", 32'(imem_req), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("s3_req_hold2", 32'(imem_req), 32'h0);
        chk("s3_instr_kept", InstrD, 32'h0 ^ KEY);
        go(1'b1);
        chk("s3_req_release", 32'(imem_req), 32'h0);
        go(1'b1);
        chk("s3_pcd", PCD, 32'h4);
        chk("s3_req", 32'(imem_req), 32'h1);
        chk("s3_addr", imem_addr, 32'h8);

        // jalr to 0x301 with FlushD.
        do_reset();
        go(1'b1); go(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h301, 1'b1);
        go(1'b1);
        chk("s4_instr", InstrD, NOP);
        chk("s4_valid", 32'(ValidD), 32'h0);
        chk("s4_addr", imem_addr, 32'h300);
        chk("s4_req", 32'(imem_req), 32'h1);

        // Redirect target with bit 1 set.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 1'b1);
        go(1'b1);
`ifdef FETCH_MISALIGN_EN
        chk("s5_fault", 32'(MisalignF), 32'h1);
        chk("s5_noreq", 32'(imem_req), 32'h0);
        go(1'b1); go(1'b1);
        chk("s5_sticky", 32'(MisalignF), 32'h1);
        chk("s5_noreq2", 32'(imem_req), 32'h0);
        do_reset();
        go(1'b1);
        chk("s5_cleared", 32'(MisalignF), 32'h0);
        chk("s5_req_again", 32'(imem_req), 32'h1);
`else
        chk("s5_nofault", 32'(MisalignF), 32'h0);
        chk("s5_aligned", imem_addr, 32'h100);
        chk("s5_req", 32'(imem_req), 32'h1);
`endif

        // Randomized traffic with occasional mid-transaction resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tg, al;
            tg = $urandom & 32'h0000_fffc;
            al = $urandom & 32'h0000_fffc;
            if ($urandom_range(0, 9) == 0) tg[1] = 1'b1;
            if ($urandom_range(0, 9) == 0) al[1] = 1'b1;
            al[0] = 1'($urandom_range(0, 1));
            mem_lat = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(1, 3));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 1) == 1, tg, al, $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
